// File: rtl/snake_pkg.sv
// Shared constants and types for the snake body controller.
// Start pose, direction codes, grid defaults and FSM states.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam int GRID_W_DEF = 7;
  localparam int GRID_H_DEF = 6;

  localparam int START_HEAD_X = 2;
  localparam int START_Y      = 2;
  localparam int START_LEN    = 3;

  typedef enum logic {
    ST_RUN,
    ST_OVER
  } state_t;

endpackage

// File: rtl/snake_body_ctrl_next_head.sv
// Combinational next-head calculator with wall detection.
// Wrapping is selected by i_Wrap (driven from SNAKE_WRAP_EN at the top).
module snake_next_head
  import snake_pkg::*;
#(
  parameter int X_WIDTH = 3,
  parameter int Y_WIDTH = 3,
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF
) (
  input  logic [X_WIDTH-1:0] i_Head_X,
  input  logic [Y_WIDTH-1:0] i_Head_Y,
  input  logic [1:0]         i_Dir,
  input  logic               i_Wrap,
  output logic [X_WIDTH-1:0] o_Next_X,
  output logic [Y_WIDTH-1:0] o_Next_Y,
  output logic               o_Wall_Hit
);

  localparam logic [X_WIDTH:0] X_ONE = (X_WIDTH+1)'(1);
  localparam logic [Y_WIDTH:0] Y_ONE = (Y_WIDTH+1)'(1);

  logic [X_WIDTH:0] w_X;
  logic [Y_WIDTH:0] w_Y;
  logic             w_Out_X;
  logic             w_Out_Y;

  always_comb begin
    w_X = {1'b0, i_Head_X};
    w_Y = {1'b0, i_Head_Y};
    unique case (i_Dir)
      DIR_UP:    w_Y = w_Y - Y_ONE;
      DIR_RIGHT: w_X = w_X + X_ONE;
      DIR_DOWN:  w_Y = w_Y + Y_ONE;
      DIR_LEFT:  w_X = w_X - X_ONE;
    endcase
    // underflow lands on a large value with the extra bit set
    w_Out_X = (w_X >= (X_WIDTH+1)'(GRID_W));
    w_Out_Y = (w_Y >= (Y_WIDTH+1)'(GRID_H));
    o_Wall_Hit = !i_Wrap && (w_Out_X || w_Out_Y);
    o_Next_X = w_X[X_WIDTH-1:0];
    o_Next_Y = w_Y[Y_WIDTH-1:0];
    if (i_Wrap && w_Out_X)
      o_Next_X = (i_Dir == DIR_LEFT) ? X_WIDTH'(GRID_W-1) : '0;
    if (i_Wrap && w_Out_Y)
      o_Next_Y = (i_Dir == DIR_UP) ? Y_WIDTH'(GRID_H-1) : '0;
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake head/body tracker: steps, grows on apple, detects collisions.
// Build option: define SNAKE_WRAP_EN to make the grid edges wrap.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int X_WIDTH   = 3,
  parameter int Y_WIDTH   = 3,
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_LEN   = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_Step,
  input  logic [1:0]           i_Dir,
  input  logic [X_WIDTH-1:0]   i_Apple_X,
  input  logic [Y_WIDTH-1:0]   i_Apple_Y,
  input  logic [X_WIDTH-1:0]   i_Query_X,
  input  logic [Y_WIDTH-1:0]   i_Query_Y,
  output logic                 o_Advance,
  output logic [X_WIDTH-1:0]   o_Head_X,
  output logic [Y_WIDTH-1:0]   o_Head_Y,
  output logic [LEN_WIDTH-1:0] o_Length,
  output logic                 o_Query_Hit,
  output logic                 o_Game_Over
);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  logic [X_WIDTH-1:0]   r_Seg_X [MAX_LEN];
  logic [Y_WIDTH-1:0]   r_Seg_Y [MAX_LEN];
  logic [LEN_WIDTH-1:0] r_Len;
  logic [1:0]           r_Dir;
  logic                 r_Advance;
  state_t               r_State;

  logic [1:0]         w_Dir;
  logic [X_WIDTH-1:0] w_Next_X;
  logic [Y_WIDTH-1:0] w_Next_Y;
  logic               w_Wall;
  logic               w_Eat;
  logic               w_Self_Hit;
  logic               w_Query_Hit;

  // reversal is the opposite code: up/down and right/left differ in bit 1
  assign w_Dir = (i_Dir == (r_Dir ^ 2'd2)) ? r_Dir : i_Dir;

  snake_next_head #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H)
  ) u_next_head (
    .i_Head_X   (r_Seg_X[0]),
    .i_Head_Y   (r_Seg_Y[0]),
    .i_Dir      (w_Dir),
    .i_Wrap     (WRAP),
    .o_Next_X   (w_Next_X),
    .o_Next_Y   (w_Next_Y),
    .o_Wall_Hit (w_Wall)
  );

  assign w_Eat = (w_Next_X == i_Apple_X) && (w_Next_Y == i_Apple_Y);

  // the tail cell only counts when eating, since it then stays put
  always_comb begin
    w_Self_Hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(r_Len) - (w_Eat ? 0 : 1)) &&
          (r_Seg_X[k] == w_Next_X) && (r_Seg_Y[k] == w_Next_Y))
        w_Self_Hit = 1'b1;
    end
  end

  always_comb begin
    w_Query_Hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(r_Len)) &&
          (r_Seg_X[k] == i_Query_X) && (r_Seg_Y[k] == i_Query_Y))
        w_Query_Hit = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_State   <= ST_RUN;
      r_Dir     <= DIR_RIGHT;
      r_Advance <= 1'b0;
      r_Len     <= LEN_WIDTH'(START_LEN);
      for (int k = 0; k < MAX_LEN; k++) begin
        r_Seg_X[k] <= (k < START_LEN) ? X_WIDTH'(START_HEAD_X - k) : '0;
        r_Seg_Y[k] <= (k < START_LEN) ? Y_WIDTH'(START_Y) : '0;
      end
    end else begin
      r_Advance <= 1'b0;
      unique case (r_State)
        ST_RUN: begin
          if (i_Step) begin
            r_Dir <= w_Dir;
            if (w_Wall || w_Self_Hit) begin
              r_State <= ST_OVER;
            end else begin
              for (int k = MAX_LEN-1; k > 0; k--) begin
                r_Seg_X[k] <= r_Seg_X[k-1];
                r_Seg_Y[k] <= r_Seg_Y[k-1];
              end
              r_Seg_X[0] <= w_Next_X;
              r_Seg_Y[0] <= w_Next_Y;
              if (w_Eat) begin
                r_Advance <= 1'b1;
                if (r_Len < LEN_WIDTH'(MAX_LEN))
                  r_Len <= r_Len + LEN_WIDTH'(1);
              end
            end
          end
        end
        ST_OVER: begin
          r_State <= ST_OVER;
        end
      endcase
    end
  end

  assign o_Advance   = r_Advance;
  assign o_Head_X    = r_Seg_X[0];
  assign o_Head_Y    = r_Seg_Y[0];
  assign o_Length    = r_Len;
  assign o_Query_Hit = w_Query_Hit;
  assign o_Game_Over = (r_State == ST_OVER);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: directed moves, queued expectations.
// Wall expectations follow SNAKE_WRAP_EN when it is defined.
module tb_snake_body_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n;
  logic       i_Step;
  logic [1:0] i_Dir;
  logic [2:0] i_Apple_X, i_Apple_Y;
  logic [2:0] i_Query_X, i_Query_Y;
  logic       o_Advance;
  logic [2:0] o_Head_X, o_Head_Y;
  logic [3:0] o_Length;
  logic       o_Query_Hit;
  logic       o_Game_Over;

  localparam logic [1:0] U = 2'd0, R = 2'd1, D = 2'd2, L = 2'd3;

  snake_body_ctrl dut (
    .i_Clk       (i_Clk),
    .i_Reset_n   (i_Reset_n),
    .i_Step      (i_Step),
    .i_Dir       (i_Dir),
    .i_Apple_X   (i_Apple_X),
    .i_Apple_Y   (i_Apple_Y),
    .i_Query_X   (i_Query_X),
    .i_Query_Y   (i_Query_Y),
    .o_Advance   (o_Advance),
    .o_Head_X    (o_Head_X),
    .o_Head_Y    (o_Head_Y),
    .o_Length    (o_Length),
    .o_Query_Hit (o_Query_Hit),
    .o_Game_Over (o_Game_Over)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    string nm;
    bit    st;
    int    hx;
    int    hy;
    int    len;
    int    ov;
    int    adv;
    int    qhit;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // monitor: one expectation per cycle, checked mid-cycle
  always @(negedge i_Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.st) begin
        chk({e.nm, ".hx"}, int'(o_Head_X), e.hx);
        chk({e.nm, ".hy"}, int'(o_Head_Y), e.hy);
        chk({e.nm, ".len"}, int'(o_Length), e.len);
        chk({e.nm, ".over"}, int'(o_Game_Over), e.ov);
        chk({e.nm, ".adv"}, int'(o_Advance), e.adv);
      end else begin
        chk({e.nm, ".qhit"}, int'(o_Query_Hit), e.qhit);
      end
    end
  end

  task automatic push_st(string nm, int hx, int hy, int len, int ov, int adv);
    exp_t e;
    e.nm = nm; e.st = 1'b1;
    e.hx = hx; e.hy = hy; e.len = len;
    e.ov = ov; e.adv = adv; e.qhit = 0;
    q.push_back(e);
  endtask

  task automatic cyc(string nm, bit stp, logic [1:0] d,
                     int hx, int hy, int len, int ov, int adv);
    i_Step = stp;
    i_Dir = d;
    @(posedge i_Clk); #1;
    i_Step = 1'b0;
    push_st(nm, hx, hy, len, ov, adv);
  endtask

  task automatic rst(string nm);
    i_Reset_n = 1'b0;
    i_Step = 1'b0;
    @(posedge i_Clk); #1;
    i_Reset_n = 1'b1;
    push_st(nm, 2, 2, 3, 0, 0);
  endtask

  task automatic qchk(string nm, int x, int y, int hit);
    exp_t e;
    @(posedge i_Clk); #1;
    i_Query_X = 3'(x);
    i_Query_Y = 3'(y);
    e.nm = nm; e.st = 1'b0;
    e.hx = 0; e.hy = 0; e.len = 0;
    e.ov = 0; e.adv = 0; e.qhit = hit;
    q.push_back(e);
  endtask

  task automatic apple(int x, int y);
    i_Apple_X = 3'(x);
    i_Apple_Y = 3'(y);
  endtask

  initial begin
    i_Reset_n = 1'b0;
    i_Step = 1'b0;
    i_Dir = R;
    apple(0, 5);
    i_Query_X = '0;
    i_Query_Y = '0;
    @(posedge i_Clk); #1;

    // reset pose
    rst("reset");
    qchk("q_rst_02", 0, 2, 1);
    qchk("q_rst_22", 2, 2, 1);
    qchk("q_rst_32", 3, 2, 0);
    qchk("q_rst_00", 0, 0, 0);

    // eat and grow
    apple(3, 2);
    cyc("eat1", 1, R, 3, 2, 4, 0, 1);
    apple(0, 5);
    cyc("eat1_idle", 0, R, 3, 2, 4, 0, 0);
    qchk("q_eat_tail", 0, 2, 1);

    // reversal ignored
    rst("rst_rev");
    cyc("rev1", 1, L, 3, 2, 3, 0, 0);
    cyc("rev2", 1, L, 4, 2, 3, 0, 0);

    // wall
    rst("rst_wall");
    cyc("wall_s1", 1, R, 3, 2, 3, 0, 0);
    cyc("wall_s2", 1, R, 4, 2, 3, 0, 0);
    cyc("wall_s3", 1, R, 5, 2, 3, 0, 0);
    cyc("wall_s4", 1, R, 6, 2, 3, 0, 0);
`ifdef SNAKE_WRAP_EN
    cyc("wall_wrap", 1, R, 0, 2, 3, 0, 0);
    cyc("wall_wrap2", 1, R, 1, 2, 3, 0, 0);
`else
    cyc("wall_hit", 1, R, 6, 2, 3, 1, 0);
    cyc("wall_frozen", 1, D, 6, 2, 3, 1, 0);
    qchk("q_over_body", 4, 2, 1);
`endif

    // tail chase, legal
    rst("rst_tail");
    apple(3, 2);
    cyc("tail_eat", 1, R, 3, 2, 4, 0, 1);
    apple(0, 5);
    cyc("tail_d", 1, D, 3, 3, 4, 0, 0);
    cyc("tail_l", 1, L, 2, 3, 4, 0, 0);
    cyc("tail_u_ok", 1, U, 2, 2, 4, 0, 0);
    qchk("q_tail_23", 2, 3, 1);
    qchk("q_tail_12", 1, 2, 0);

    // tail chase with apple on tail cell
    rst("rst_tail2");
    apple(3, 2);
    cyc("tail2_eat", 1, R, 3, 2, 4, 0, 1);
    apple(0, 5);
    cyc("tail2_d", 1, D, 3, 3, 4, 0, 0);
    cyc("tail2_l", 1, L, 2, 3, 4, 0, 0);
    apple(2, 2);
    cyc("tail2_u_over", 1, U, 2, 3, 4, 1, 0);
    cyc("tail2_idle", 0, U, 2, 3, 4, 1, 0);

    // saturation
    rst("rst_sat");
    apple(3, 2); cyc("sat4", 1, R, 3, 2, 4, 0, 1);
    apple(4, 2); cyc("sat5", 1, R, 4, 2, 5, 0, 1);
    apple(5, 2); cyc("sat6", 1, R, 5, 2, 6, 0, 1);
    apple(6, 2); cyc("sat7", 1, R, 6, 2, 7, 0, 1);
    apple(6, 3); cyc("sat8", 1, D, 6, 3, 8, 0, 1);
    apple(5, 3); cyc("sat8b", 1, L, 5, 3, 8, 0, 1);
    apple(0, 5);
    cyc("sat_idle", 0, L, 5, 3, 8, 0, 0);
    qchk("q_sat_02", 0, 2, 0);
    qchk("q_sat_12", 1, 2, 1);

    // self-collision at length 6, then reset mid-game
    rst("rst_mid");
    apple(3, 2); cyc("mid4", 1, R, 3, 2, 4, 0, 1);
    apple(4, 2); cyc("mid5", 1, R, 4, 2, 5, 0, 1);
    apple(5, 2); cyc("mid6", 1, R, 5, 2, 6, 0, 1);
    apple(0, 5);
    cyc("mid_d", 1, D, 5, 3, 6, 0, 0);
    cyc("mid_l", 1, L, 4, 3, 6, 0, 0);
    cyc("mid_hit", 1, U, 4, 3, 6, 1, 0);
    cyc("mid_frozen", 1, L, 4, 3, 6, 1, 0);
    qchk("q_mid_32", 3, 2, 1);
    qchk("q_mid_12", 1, 2, 0);
    rst("rst_after_over");
    qchk("q_ra_02", 0, 2, 1);
    qchk("q_ra_12", 1, 2, 1);
    qchk("q_ra_22", 2, 2, 1);
    qchk("q_ra_32", 3, 2, 0);
    qchk("q_ra_43", 4, 3, 0);

    repeat (4) @(posedge i_Clk);
    if (q.size() != 0)
      chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
